// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers: window length, column
// count, accumulator width and the output-pixel record.
package cnn_pkg;

  localparam int WORDWIDTH = 32;
  localparam int NUM1      = 14;
  localparam int NUM2      = 5;
  localparam int CHANNEL   = 6;

  function automatic int win_len(input int ch, input int k);
    return ch * k;
  endfunction

  function automatic int col_cnt(input int n1, input int k);
    return n1 + 1 - k;
  endfunction

  function automatic int accw(input int w, input int ch, input int k);
    return w + $clog2(ch * k);
  endfunction

  localparam int WIN  = win_len(CHANNEL, NUM2);
  localparam int COLS = col_cnt(NUM1, NUM2);
  localparam int COLW = $clog2(COLS);
  localparam int ACCW = accw(WORDWIDTH, CHANNEL, NUM2);

  typedef struct packed {
    logic [WORDWIDTH-1:0] data;
    logic [COLW-1:0]      col;
    logic [COLW-1:0]      row;
  } pix_t;

endpackage

// File: rtl/pe_accum_fifo.sv
// Small synchronous FIFO for finished pixels; a push is accepted
// while full if a pop happens in the same cycle.
module pe_accum_fifo
  import cnn_pkg::*;
#(
  parameter type T     = pix_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        do_pop;
  logic        do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/pe_accum.sv
// Partial-sum accumulator with saturation, column/row tagging and an
// output FIFO. Define PE_ACCUM_RELU_EN to clamp negative pixels to 0.
module pe_accum
  import cnn_pkg::*;
#(
  parameter int WORDWIDTH  = cnn_pkg::WORDWIDTH,
  parameter int NUM1       = cnn_pkg::NUM1,
  parameter int NUM2       = cnn_pkg::NUM2,
  parameter int CHANNEL    = cnn_pkg::CHANNEL,
  parameter int FIFO_DEPTH = 4,
  localparam int CW   = $clog2(win_len(CHANNEL, NUM2)),
  localparam int COLW = $clog2(col_cnt(NUM1, NUM2))
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        prod_valid,
  input  logic signed [WORDWIDTH-1:0] prod_data,
  input  logic [CW-1:0]               count1,
  input  logic [COLW-1:0]             count2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORDWIDTH-1:0]        out_data,
  output logic [COLW-1:0]             out_col,
  output logic [COLW-1:0]             out_row,
  output logic                        sat_flag,
  output logic                        drop_err,
  output logic                        seq_err
);

  localparam int WINL  = win_len(CHANNEL, NUM2);
  localparam int COLSL = col_cnt(NUM1, NUM2);
  localparam int AW    = accw(WORDWIDTH, CHANNEL, NUM2);
  localparam int XW    = AW - WORDWIDTH;

  localparam logic signed [AW-1:0] MAXV =
    {{(XW+1){1'b0}}, {(WORDWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(XW+1){1'b1}}, {(WORDWIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WORDWIDTH-1:0] data;
    logic [COLW-1:0]      col;
    logic [COLW-1:0]      row;
  } entry_t;

  logic signed [AW-1:0]        acc_q, acc_d;
  logic signed [AW-1:0]        sum;
  logic [CW-1:0]               exp_q, exp_d;
  logic [COLW-1:0]             row_q, row_d;
  logic                        sat_q, drop_q, seq_q;
  logic                        beat, first, last;
  logic                        push, pop, full, empty;
  logic                        clamp_hi, clamp_lo;
  logic [WORDWIDTH-1:0]        sat_v, res_v;
  entry_t                      wr_e, rd_e;

  assign beat  = en & prod_valid;
  assign first = (count1 == '0);
  assign last  = (count1 == CW'(WINL - 1));
  assign push  = beat & last;
  assign pop   = out_valid & out_ready;

  always_comb begin
    sum = (first ? '0 : acc_q) +
          {{XW{prod_data[WORDWIDTH-1]}}, prod_data};
    clamp_hi = (sum > MAXV);
    clamp_lo = (sum < MINV);
    sat_v = sum[WORDWIDTH-1:0];
    if (clamp_hi) sat_v = MAXV[WORDWIDTH-1:0];
    if (clamp_lo) sat_v = MINV[WORDWIDTH-1:0];
`ifdef PE_ACCUM_RELU_EN
    res_v = sat_v[WORDWIDTH-1] ? '0 : sat_v;
`else
    res_v = sat_v;
`endif
  end

  always_comb begin
    acc_d = acc_q;
    exp_d = exp_q;
    row_d = row_q;
    if (!en) begin
      acc_d = '0;
      exp_d = '0;
      row_d = '0;
    end else if (beat) begin
      acc_d = sum;
      exp_d = last ? '0 : count1 + CW'(1);
      // a lost pixel still occupies its raster position
      if (last && count2 == COLW'(COLSL - 1))
        row_d = (row_q == COLW'(COLSL - 1)) ? '0 : row_q + COLW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      exp_q  <= '0;
      row_q  <= '0;
      sat_q  <= 1'b0;
      drop_q <= 1'b0;
      seq_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      exp_q  <= exp_d;
      row_q  <= row_d;
      sat_q  <= sat_q | (push & (clamp_hi | clamp_lo));
      drop_q <= drop_q | (push & full & ~pop);
      seq_q  <= seq_q | (beat & (count1 != exp_q));
    end
  end

  assign wr_e = '{data: res_v, col: count2, row: row_q};

  pe_accum_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (wr_e),
    .pop_i   (pop),
    .dout_o  (rd_e),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_valid = ~empty;
  assign out_data  = rd_e.data;
  assign out_col   = rd_e.col;
  assign out_row   = rd_e.row;
  assign sat_flag  = sat_q;
  assign drop_err  = drop_q;
  assign seq_err   = seq_q;

endmodule

// File: tb/tb_pe_accum.sv
// Self-checking bench for pe_accum: queue-based pixel model checked
// every cycle, plus directed windows with literal expectations.
module tb_pe_accum;

  localparam int  WIN   = 30;
  localparam int  COLS  = 10;
  localparam int  DEPTH = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               prod_valid;
  logic signed [31:0] prod_data;
  logic [4:0]         count1;
  logic [3:0]         count2;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [3:0]         out_col;
  logic [3:0]         out_row;
  logic               sat_flag;
  logic               drop_err;
  logic               seq_err;

  pe_accum dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .count1     (count1),
    .count2     (count2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_col    (out_col),
    .out_row    (out_row),
    .sat_flag   (sat_flag),
    .drop_err   (drop_err),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  // Behavioural model: pixels in flight as a queue of records.
  typedef struct {
    longint data;
    int     col;
    int     row;
  } px_t;

  px_t    q[$];
  longint macc, p, s;
  int     mexp, mrow;
  bit     msat, mdrop, mseq;
  bit     popv, mfull;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      macc = 0; mexp = 0; mrow = 0;
      msat = 0; mdrop = 0; mseq = 0;
    end else begin
      popv  = (q.size() > 0) && out_ready;
      mfull = (q.size() == DEPTH);
      if (popv) void'(q.pop_front());
      if (!en) begin
        macc = 0; mexp = 0; mrow = 0;
      end else if (prod_valid) begin
        p = longint'(prod_data);
        if (int'(count1) != mexp) mseq = 1;
        macc = (count1 == 0) ? p : macc + p;
        mexp = (int'(count1) + 1) % WIN;
        if (count1 == WIN - 1) begin
          s = macc;
          if (s > MAXV) begin s = MAXV; msat = 1; end
          if (s < MINV) begin s = MINV; msat = 1; end
`ifdef PE_ACCUM_RELU_EN
          if (s < 0) s = 0;
`endif
          if (mfull && !popv) mdrop = 1;
          else q.push_back('{s, int'(count2), mrow});
          if (count2 == COLS - 1) mrow = (mrow + 1) % COLS;
        end
      end
    end
  end

  logic [31:0] mdata;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", {63'b0, out_valid}, {63'b0, q.size() > 0});
      if (q.size() > 0) begin
        mdata = q[0].data[31:0];
        chk("data", {32'b0, out_data}, {32'b0, mdata});
        chk("col", {60'b0, out_col}, 64'(q[0].col));
        chk("row", {60'b0, out_row}, 64'(q[0].row));
      end
      chk("sat", {63'b0, sat_flag}, {63'b0, msat});
      chk("drop", {63'b0, drop_err}, {63'b0, mdrop});
      chk("seq", {63'b0, seq_err}, {63'b0, mseq});
    end
  end

  task automatic cyc(input bit e, input bit v, input logic [31:0] d,
                     input int c1, input int c2);
    @(negedge clk);
    en = e; prod_valid = v; prod_data = d;
    count1 = c1[4:0]; count2 = c2[3:0];
  endtask

  task automatic idle();
    cyc(1, 0, 32'h0, 0, 0);
  endtask

  task automatic window(input logic [31:0] d, input int c2);
    for (int i = 0; i < WIN; i++) cyc(1, 1, d, i, c2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; en = 0; prod_valid = 0;
    idle(); idle();
    rst = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1;
    while (out_valid && n < 20) begin idle(); n++; end
    if (out_valid) chk("drain_timeout", 64'd1, 64'd0);
    out_ready = 0;
  endtask

  int step, r, sel;
  logic [31:0] rv;

  initial begin
    rst = 1; en = 0; prod_valid = 0; prod_data = 0;
    count1 = 0; count2 = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_data", {32'b0, out_data}, 64'd0);
    chk("rst_col", {60'b0, out_col}, 64'd0);
    chk("rst_row", {60'b0, out_row}, 64'd0);
    chk("rst_flags", {61'b0, sat_flag, drop_err, seq_err}, 64'd0);
    chk_on = 1;

    window(32'd1, 3);
    idle();
    chk("ones_valid", {63'b0, out_valid}, 64'd1);
    chk("ones_data", {32'b0, out_data}, 64'd30);
    chk("ones_col", {60'b0, out_col}, 64'd3);
    chk("ones_row", {60'b0, out_row}, 64'd0);
    chk("ones_flags", {61'b0, sat_flag, drop_err, seq_err}, 64'd0);
    drain();

    do_reset();
    window(32'h7FFFFFFF, 0);
    idle();
    chk("satp_data", {32'b0, out_data}, 64'h7FFFFFFF);
    chk("satp_flag", {63'b0, sat_flag}, 64'd1);
    drain();
    window(32'h80000000, 0);
    idle();
    chk("satn_data", {32'b0, out_data}, 64'h80000000);
    drain();

    do_reset();
    for (int k = 0; k < 5; k++) window(32'(k + 1), k);
    idle();
    chk("full_drop", {63'b0, drop_err}, 64'd1);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("pop_valid", {63'b0, out_valid}, 64'd1);
      chk("pop_col", {60'b0, out_col}, 64'(k));
      chk("pop_data", {32'b0, out_data}, 64'(30 * (k + 1)));
      idle();
    end
    chk("pop_empty", {63'b0, out_valid}, 64'd0);
    out_ready = 0;

    do_reset();
    window(32'hFFFFFFFF, 2);
    idle();
`ifdef PE_ACCUM_RELU_EN
    chk("neg_data", {32'b0, out_data}, 64'd0);
`else
    chk("neg_data", {32'b0, out_data}, 64'hFFFFFFE2);
`endif
    drain();

    do_reset();
    for (int i = 0; i < WIN; i++) if (i != 5) cyc(1, 1, 32'd2, i, 0);
    idle();
    chk("seq_flag", {63'b0, seq_err}, 64'd1);

    do_reset();
    for (int i = 0; i < 15; i++) cyc(1, 1, 32'd3, i, 0);
    cyc(1, 1, 32'd3, 15, 0);
    rst = 1;
    idle();
    rst = 0;
    idle();
    chk("rstmid_none", {63'b0, out_valid}, 64'd0);
    window(32'd5, 1);
    idle();
    chk("rstmid_data", {32'b0, out_data}, 64'd150);
    chk("rstmid_row", {60'b0, out_row}, 64'd0);
    chk("rstmid_seq", {63'b0, seq_err}, 64'd0);
    drain();

    do_reset();
    out_ready = 1;
    for (int k = 0; k < COLS; k++) window(32'(k), k);
    window(32'd7, 0);
    idle();
    chk("row_valid", {63'b0, out_valid}, 64'd1);
    chk("row_row", {60'b0, out_row}, 64'd1);
    chk("row_col", {60'b0, out_col}, 64'd0);
    chk("row_data", {32'b0, out_data}, 64'd210);
    idle();
    out_ready = 0;

    do_reset();
    step = 0;
    for (int n = 0; n < 4000; n++) begin
      r   = $urandom_range(0, 999);
      sel = $urandom_range(0, 3);
      case (sel)
        0: rv = 32'($signed($urandom_range(0, 2000)) - 1000);
        1: rv = $urandom;
        2: rv = 32'h7FFFFFFF;
        default: rv = 32'h80000000;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      if (r < 3) begin
        cyc(1, 0, 32'h0, 0, 0);
        rst = 1;
        step = 0;
      end else if (r < 13) begin
        cyc(0, 1, rv, step, 0);
        step = 0;
      end else if (r < 700) begin
        if ($urandom_range(0, 49) == 0) step = $urandom_range(0, WIN - 1);
        cyc(1, 1, rv, step, $urandom_range(0, COLS - 1));
        step = (step + 1) % WIN;
      end else begin
        cyc(1, 0, rv, step, 0);
      end
      if (r >= 3) rst = 0;
    end
    rst = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_accum.md
# pe_accum

Partial-sum accumulator and result buffer sitting directly downstream of the PE array and its `pe_control` counter block. It consumes one signed product beat per valid cycle and sums each CHANNEL×NUM2 window into one output pixel. Completed pixels are saturated and tagged with their output column/row, then queued in a small FIFO. The feature-map writer drains the FIFO through a valid/ready handshake.

## Interface
Parameters:
- `WORDWIDTH`, 32: product and output word width (signed two's complement).
- `NUM1`, 14: input feature-map width/height.
- `NUM2`, 5: kernel size.
- `CHANNEL`, 6: input channels per window.
- `FIFO_DEPTH`, 4: output queue entries (power of two, ≥2).

Ports:
- `clk` input 1: clock; single clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: layer active; same enable that drives `pe_control`.
- `prod_valid` input 1: product beat present.
- `prod_data` input WORDWIDTH: signed PE product.
- `count1` input $clog2(CHANNEL*NUM2): window step index (0..CHANNEL*NUM2-1), sampled with the beat.
- `count2` input $clog2(NUM1+1-NUM2): output column index, sampled with the beat.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer accepts head.
- `out_data` output WORDWIDTH: saturated pixel value.
- `out_col` output $clog2(NUM1+1-NUM2): column tag.
- `out_row` output $clog2(NUM1+1-NUM2): row tag.
- `sat_flag` output 1: sticky; some pixel saturated.
- `drop_err` output 1: sticky; a pixel was lost to a full FIFO.
- `seq_err` output 1: sticky; window step sequence broken.

## Operation
- Beat = `en & prod_valid`. No beat: all state holds.
- Accumulator width ACCW = WORDWIDTH + $clog2(CHANNEL*NUM2), signed.
- Beat with `count1==0`: acc ← sext(prod_data). Otherwise: acc ← acc + sext(prod_data).
- Beat with `count1==CHANNEL*NUM2-1` is the final beat. Sum = acc + prod_data, clamped to [−2^(WORDWIDTH−1), 2^(WORDWIDTH−1)−1].
  - The clamp sets `sat_flag` when it changes the value.
  - The result is pushed to the FIFO with `count2` as column and the internal row counter as row.
- Row counter increments after a push whose column == NUM1−NUM2. It wraps to 0 after NUM1−NUM2.
- Expected-step tracker: a beat whose `count1` ≠ previous beat's `count1`+1 (mod CHANNEL*NUM2) sets `seq_err`. Accumulation still follows the `count1==0` rule.
- FIFO full at push and no pop that cycle: result discarded, `drop_err` set. Full with simultaneous pop: push accepted.
- `en` low: accumulator, step tracker and row counter cleared. FIFO contents and sticky flags retained. Draining continues.
- `rst`: all state cleared. Reset values: `out_valid`=0, `out_data`=0, `out_col`=0, `out_row`=0, all sticky flags 0, FIFO empty.

## Timing
- Product-to-accumulator: 1 cycle (registered acc).
- Final beat to `out_valid` high (FIFO empty): 1 cycle.
- Pop when `out_valid & out_ready`. The next head is presented the following cycle; no bubble when FIFO holds ≥2.
- `out_data`/`out_col`/`out_row` stable while `out_valid & ~out_ready`.
- Sticky flags assert the cycle after the triggering beat and clear only on `rst`.
- Back-to-back windows (final beat followed immediately by `count1==0`) are supported at full rate.
- `rst` mid-window: partial sum lost, no push.

## Configuration
- `PE_ACCUM_RELU_EN` defined: ReLU applied after saturation; negative results are pushed as 0.
- Not defined: the signed saturated value is pushed unchanged.
- `sat_flag` semantics are unaffected in both builds.

## Structure
- Shared package `cnn_pkg`:
  - window-length constant CHANNEL*NUM2;
  - column count NUM1+1−NUM2;
  - ACCW derivation;
  - FIFO entry struct {data, col, row}.
- One sub-module: `pe_accum_fifo`, a synchronous FIFO with push/pop/full/empty and same-cycle push+pop when full.
- Accumulate, saturate, ReLU and tag logic are in the top.

## Test plan
- 30 beats of `prod_data`=1, count1 0..29, count2=3 → one pixel: `out_data`=30, `out_col`=3, `out_row`=0, no flags.
- 30 beats of 0x7FFFFFFF → `out_data`=0x7FFFFFFF, `sat_flag`=1. Repeat with 0x80000000 → `out_data`=0x80000000.
- `out_ready`=0, five complete windows → four entries held, `drop_err`=1. Then `out_ready`=1 → four pops in four consecutive cycles, in order.
- 30 beats of −1:
  - with `PE_ACCUM_RELU_EN` → `out_data`=0;
  - without it → `out_data`=0xFFFFFFE2.
- `count1` jumps 4→6 mid-window → `seq_err`=1. `rst` pulsed at beat 15 → no output; the next full window yields the correct sum with `out_row`=0.
- Ten full windows with count2 0..9 → `out_row` is 0 for all ten; the eleventh window has `out_row`=1, `out_col`=0.
